seq_magnitude_comparator: RTL
=============================

Name: seq_magnitude_comparator

Overview:
Parametrised, multi-cycle magnitude comparator for two WIDTH-bit operands, with a selectable signed or unsigned mode. A start/busy/done handshake launches each comparison. The block examines CHUNK bits per cycle, most significant chunk first, and terminates early at the first chunk that differs. It sits next to datapath blocks that need wide compares with a bounded combinational depth, and drives registered one-hot GT/LT/EQ flags.

Parameters:
WIDTH, 16, operand width in bits; must be a positive multiple of CHUNK
CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH
NCHUNK, WIDTH/CHUNK (localparam), number of compare steps; counter width is clog2(NCHUNK)+1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a compare; accepted only in IDLE or DONE
a  in  WIDTH  operand A, sampled on the accepted start edge
b  in  WIDTH  operand B, sampled on the accepted start edge
signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; sampled with the operands
busy  out  1  compare in progress (state COMPARE)
done  out  1  one-cycle pulse; results are valid from this cycle on
GT  out  1  registered, A > B
LT  out  1  registered, A < B
EQ  out  1  registered, A == B

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, GT=0, LT=0, EQ=0; shadow registers and counter cleared. Reset asserted mid-compare aborts it immediately with no done pulse.
- States and transitions:
  - IDLE --start--> COMPARE.
  - COMPARE --(chunk differs) or (last chunk equal)--> DONE.
  - DONE --start--> COMPARE.
  - DONE --no start--> IDLE.
- Accepted start:
  - Capture a and b into shadow registers sa and sb.
  - If signed_mode=1, invert bit WIDTH-1 of both sa and sb at capture. Signed order then equals unsigned order on the modified values, so a single unsigned chunk compare serves both modes.
  - Load the counter with NCHUNK-1.
  - Clear GT, LT and EQ to 0.
- start while busy=1 is ignored; it is neither queued nor allowed to corrupt the compare in flight.
- COMPARE cycle:
  - Compare the top chunk, sa[WIDTH-1 -: CHUNK] against sb[WIDTH-1 -: CHUNK], as unsigned values.
  - If the chunk of sa is greater: GT<=1, go to DONE.
  - If the chunk of sa is less: LT<=1, go to DONE.
  - If equal and counter==0: EQ<=1, go to DONE.
  - If equal and counter>0: shift sa and sb left by CHUNK, decrement the counter, stay in COMPARE.
- Latency: done asserts k cycles after the start edge, where k is the 1-based index, from the MSB end, of the first differing chunk. k = NCHUNK when the operands are equal. Best case is 1 cycle, worst case NCHUNK cycles.
- DONE lasts exactly one cycle, with done=1 and busy=0.
- GT/LT/EQ are exactly one-hot from the done cycle until the next accepted start or reset. All three are 0 while busy.
- A start in the DONE cycle is accepted, which allows back-to-back compares. Throughput is one compare per k+1 cycles.
- CHUNK==WIDTH degenerates to a one-step compare with done 1 cycle after start. The design must handle it with no zero-width counter.

Decomposition:
- Shared package cmp_pkg:
  - State enum {IDLE, COMPARE, DONE}.
  - Function or constant for the counter width, clog2(NCHUNK)+1.
  - Result encoding constants, used by the bench.
- Sub-module cmp_chunk_slice: purely combinational CHUNK-bit unsigned compare producing gt/lt/eq. It is instantiated once, on the top chunk of the shadow registers.
- The top level holds the FSM, the shadow shift registers, the counter and the output registers.

Test Plan:
1. WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1234 -> busy for 4 cycles; done 4 cycles after start; EQ=1, GT=0, LT=0.
2. a=0x8000, b=0x7FFF: with signed_mode=0 -> GT=1 with done after 1 cycle; with signed_mode=1 -> LT=1 with done after 1 cycle.
3. Unsigned, a=0x12A4, b=0x12B4 -> LT=1 with done after 3 cycles. Also a=0xFFFF, b=0xFFFE -> GT=1 after 4 cycles. Signed a=0xFFFF (-1), b=0x0001 -> LT=1.
4. Pulse start again during busy with different operands -> ignored; the original result is reported. Assert start in the done cycle -> the new compare is accepted, flags clear the next cycle, and the second result is correct.
5. Drop rst_n asynchronously in the second COMPARE cycle -> all outputs 0 immediately and no done pulse; a fresh start after release completes normally.
6. Reconfigure with CHUNK=16 and CHUNK=1 (WIDTH=16) and run randomized a, b and signed_mode against a reference model -> flags match, and latency equals the first-differing-chunk index.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   cmp_state_t : controller states
//   cnt_width() : chunk counter width for a given chunk count
//   RES_*       : {GT,LT,EQ} result encodings
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } cmp_state_t;

  // One extra bit keeps the counter at least 1 bit wide when there is a single chunk.
  function automatic int cnt_width(input int nchunk);
    return $clog2(nchunk) + 1;
  endfunction

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_LT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

endpackage

// File: rtl/cmp_chunk_slice.sv
// Combinational unsigned compare of one CHUNK-bit slice.
//   x, y : slices to compare
//   gt   : x > y,  lt : x < y,  eq : x == y
module cmp_chunk_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (x > y);
  assign lt = (x < y);
  assign eq = (x == y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB chunk
// first, stopping at the first differing chunk. Signed or unsigned mode.
//   clk, rst_n     : clock, async active-low reset
//   start          : launch a compare (accepted in IDLE or DONE)
//   a, b           : operands, sampled on the accepted start edge
//   signed_mode    : 1 = two's complement, 0 = unsigned
//   busy           : compare in progress
//   done           : one-cycle pulse when the result becomes valid
//   GT, LT, EQ     : registered one-hot result, held until next start/reset
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             LT,
  output logic             EQ
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic             c_gt, c_lt, c_eq;

  cmp_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .x  (sa_q[WIDTH-1 -: CHUNK]),
    .y  (sb_q[WIDTH-1 -: CHUNK]),
    .gt (c_gt),
    .lt (c_lt),
    .eq (c_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Flipping the sign bit of both operands maps signed order onto
          // unsigned order, so one unsigned slice serves both modes.
          sa_d            = a;
          sb_d            = b;
          sa_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
          sb_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
          cnt_d           = CW'(NCHUNK - 1);
          gt_d            = 1'b0;
          lt_d            = 1'b0;
          eq_d            = 1'b0;
          state_d         = COMPARE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      COMPARE: begin
        if (c_gt) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (c_lt) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (c_eq && (cnt_q == '0)) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          sa_d  = sa_q << CHUNK;
          sb_d  = sb_q << CHUNK;
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == COMPARE);
  assign done = (state_q == DONE);
  assign GT   = gt_q;
  assign LT   = lt_q;
  assign EQ   = eq_q;

endmodule
